// File: rtl/operand_fetch_if.sv
// operand_fetch_if: upstream, register-file read port, write snoop and execute-side signals of operand_fetch.
interface operand_fetch_if #(
    parameter int WIDTH = 32,
    parameter int N     = 32
);
    localparam int AW = $clog2(N);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_rs1_addr;
    logic [AW-1:0]    in_rs2_addr;
    logic [AW-1:0]    in_rd_addr;
    logic             rf_read_en;
    logic [AW-1:0]    rf_read_addr;
    logic [WIDTH-1:0] rf_read_data;
    logic             wb_write_en;
    logic [AW-1:0]    wb_write_addr;
    logic [WIDTH-1:0] wb_write_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_rs1_data;
    logic [WIDTH-1:0] out_rs2_data;
    logic [AW-1:0]    out_rd_addr;
    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, rf_read_data,
               wb_write_en, wb_write_addr, wb_write_data, out_ready,
        input  in_ready, rf_read_en, rf_read_addr, out_valid, out_rs1_data,
               out_rs2_data, out_rd_addr
    );
    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, rf_read_data,
               wb_write_en, wb_write_addr, wb_write_data, out_ready,
        output in_ready, rf_read_en, rf_read_addr, out_valid, out_rs1_data,
               out_rs2_data, out_rd_addr
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: serializes rs1/rs2 reads on a single RF read port and hands both operands to execute.
// Define OPERAND_FETCH_BYPASS_EN to forward a same-cycle RF write into the captured operand.
module operand_fetch #(
    parameter int WIDTH = 32,
    parameter int N     = 32
) (
    input logic clk,
    input logic rst,
    operand_fetch_if.slave of_if
);
    localparam int AW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RD1, RD2, HOLD} state_e;
    state_e           state_q, state_d;
    logic [AW-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, cap;
    logic             fwd, accept;
`ifdef OPERAND_FETCH_BYPASS_EN
    assign fwd = of_if.wb_write_en && of_if.wb_write_addr == of_if.rf_read_addr && of_if.rf_read_addr != '0;
`else
    assign fwd = 1'b0;
`endif
    assign cap                = of_if.rf_read_addr == '0 ? '0 : fwd ? of_if.wb_write_data : of_if.rf_read_data;
    assign of_if.in_ready     = state_q == IDLE || (state_q == HOLD && of_if.out_ready);
    assign accept             = of_if.in_ready && of_if.in_valid;
    assign of_if.rf_read_en   = state_q == RD1 || state_q == RD2;
    assign of_if.rf_read_addr = state_q == RD1 ? rs1_q : state_q == RD2 ? rs2_q : '0;
    assign of_if.out_valid    = state_q == HOLD;
    assign of_if.out_rs1_data = op1_q;
    assign of_if.out_rs2_data = op2_q;
    assign of_if.out_rd_addr  = rd_q;
    always_comb begin
        state_d = state_q;
        rs1_d   = accept ? of_if.in_rs1_addr : rs1_q;
        rs2_d   = accept ? of_if.in_rs2_addr : rs2_q;
        rd_d    = accept ? of_if.in_rd_addr : rd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        case (state_q)
            IDLE: state_d = accept ? RD1 : IDLE;
            RD1: begin
                op1_d   = cap;
                state_d = RD2;
            end
            RD2: begin
                op2_d   = cap;
                state_d = HOLD;
            end
            default: state_d = of_if.out_ready ? (of_if.in_valid ? RD1 : IDLE) : HOLD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks of operand_fetch against a register-file array model.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp = 0;
    int   err = 0;
    logic [31:0] rf [32];
    operand_fetch_if #(.WIDTH(32), .N(32)) bus ();
    operand_fetch #(.WIDTH(32), .N(32)) dut (.clk(clk), .rst(rst), .of_if(bus));
    always #5 clk = ~clk;
    always_comb bus.rf_read_data = rf[bus.rf_read_addr];
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        assert (got === exp) else begin
            err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return a == 5'd0 ? 32'd0 : rf[a];
    endfunction
    task automatic present(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
        bus.in_valid    = 1'b1;
        bus.in_rs1_addr = a1;
        bus.in_rs2_addr = a2;
        bus.in_rd_addr  = d;
    endtask
    task automatic chk_out(input string tag, input logic [31:0] e1, input logic [31:0] e2, input logic [4:0] d);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_rs1"}, bus.out_rs1_data, e1);
        chk({tag, "_rs2"}, bus.out_rs2_data, e2);
        chk({tag, "_rd"}, {27'd0, bus.out_rd_addr}, {27'd0, d});
    endtask
    initial begin
        logic [4:0]  a1, a2, d;
        logic [31:0] e1, e2;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        bus.in_valid = 1'b0; bus.in_rs1_addr = '0; bus.in_rs2_addr = '0; bus.in_rd_addr = '0;
        bus.wb_write_en = 1'b0; bus.wb_write_addr = '0; bus.wb_write_data = '0; bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_rf_en", {31'd0, bus.rf_read_en}, 32'd0);
        chk("rst_rf_addr", {27'd0, bus.rf_read_addr}, 32'd0);
        chk("rst_rs1", bus.out_rs1_data, 32'd0);
        chk("rst_rs2", bus.out_rs2_data, 32'd0);
        chk("rst_rd", {27'd0, bus.out_rd_addr}, 32'd0);
        // basic read x3, x5
        rf[3] = 32'h11; rf[5] = 32'h22;
        present(5'd3, 5'd5, 5'd7);
        step(); bus.in_valid = 1'b0;
        chk("b_rd1_en", {31'd0, bus.rf_read_en}, 32'd1);
        chk("b_rd1_addr", {27'd0, bus.rf_read_addr}, 32'd3);
        chk("b_rd1_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        chk("b_rd2_addr", {27'd0, bus.rf_read_addr}, 32'd5);
        chk("b_rd2_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_out("b_out", 32'h11, 32'h22, 5'd7);
        chk("b_hold_ready0", {31'd0, bus.in_ready}, 32'd0);
        chk("b_hold_rf_en", {31'd0, bus.rf_read_en}, 32'd0);
        bus.out_ready = 1'b1;
        #1 chk("b_hold_ready1", {31'd0, bus.in_ready}, 32'd1);
        step(); bus.out_ready = 1'b0;
        chk("b_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        // zero register reads as 0 even if RF drives garbage
        rf[0] = 32'hDEADBEEF;
        present(5'd0, 5'd5, 5'd9);
        step(); bus.in_valid = 1'b0; step(); step();
        chk_out("zero", 32'd0, 32'h22, 5'd9);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        // same-cycle write during RD2, then a write during HOLD
        present(5'd3, 5'd5, 5'd1);
        step(); bus.in_valid = 1'b0; step();
        bus.wb_write_en = 1'b1; bus.wb_write_addr = 5'd5; bus.wb_write_data = 32'h99;
        step(); bus.wb_write_en = 1'b0; rf[5] = 32'h99;
`ifdef OPERAND_FETCH_BYPASS_EN
        e2 = 32'h99;
`else
        e2 = 32'h22;
`endif
        chk_out("byp", 32'h11, e2, 5'd1);
        bus.wb_write_en = 1'b1; bus.wb_write_data = 32'h77;
        step(); bus.wb_write_en = 1'b0; rf[5] = 32'h77;
        chk_out("byp_hold", 32'h11, e2, 5'd1);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        // backpressure then back-to-back accept from HOLD
        rf[10] = 32'hA0A0; rf[11] = 32'hB1B1; rf[12] = 32'hC2C2; rf[13] = 32'hD3D3;
        present(5'd10, 5'd11, 5'd2);
        step(); bus.in_valid = 1'b0; step(); step();
        for (int i = 0; i < 4; i++) begin
            chk_out("bp", 32'hA0A0, 32'hB1B1, 5'd2);
            chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        present(5'd12, 5'd13, 5'd4);
        #1 chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
        step(); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("b2b_rd1_addr", {27'd0, bus.rf_read_addr}, 32'd12);
        chk("b2b_rd1_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("b2b_rd2_addr", {27'd0, bus.rf_read_addr}, 32'd13);
        step();
        chk_out("b2b", 32'hC2C2, 32'hD3D3, 5'd4);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        // reset during RD2 aborts the instruction
        present(5'd3, 5'd10, 5'd6);
        step(); bus.in_valid = 1'b0; step();
        rst = 1'b1; bus.out_ready = 1'b1;
        step(); rst = 1'b0;
        chk("mr_rf_en", {31'd0, bus.rf_read_en}, 32'd0);
        chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mr_rs1", bus.out_rs1_data, 32'd0);
        chk("mr_rd", {27'd0, bus.out_rd_addr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mr_no_valid", {31'd0, bus.out_valid}, 32'd0);
            step();
        end
        bus.out_ready = 1'b0;
        // randomized instructions against the array model
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            d  = 5'($urandom_range(0, 31));
            e1 = reg_val(a1);
            e2 = reg_val(a2);
            present(a1, a2, d);
            step(); bus.in_valid = 1'b0;
            chk("rnd_rd1_addr", {27'd0, bus.rf_read_addr}, {27'd0, a1});
            step(); step();
            for (int w = $urandom_range(0, 2); w > 0; w--) step();
            chk_out("rnd", e1, e2, d);
            bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
            chk("rnd_idle", {31'd0, bus.out_valid}, 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly downstream of the core's single-read-port register file and upstream of execute. Accepts a decoded instruction's register addresses over a valid/ready handshake, issues two serialized reads (rs1, then rs2) on the register file read port, and presents both operands plus the destination address to execute over a second valid/ready handshake. It optionally forwards a same-cycle register file write so a value being written is not missed.

## Interface
- WIDTH, 32, data width of one register.
- N, 32, number of architectural registers; address width is $clog2(N).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream has a decoded instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_rs1_addr  input  $clog2(N)  source register 1.
- in_rs2_addr  input  $clog2(N)  source register 2.
- in_rd_addr  input  $clog2(N)  destination register, passed through.
- rf_read_en  output  1  register file read enable.
- rf_read_addr  output  $clog2(N)  register file read address.
- rf_read_data  input  WIDTH  register file read data, combinational from rf_read_addr.
- wb_write_en  input  1  snoop of the register file write enable.
- wb_write_addr  input  $clog2(N)  snoop of the register file write address.
- wb_write_data  input  WIDTH  snoop of the register file write data.
- out_valid  output  1  operands valid for execute.
- out_ready  input  1  execute accepts operands.
- out_rs1_data  output  WIDTH  operand 1.
- out_rs2_data  output  WIDTH  operand 2.
- out_rd_addr  output  $clog2(N)  destination register.

## Operation
- FSM states: IDLE, RD1, RD2, HOLD.
- IDLE: in_ready=1. in_valid=1 latches rs1/rs2/rd addresses → RD1.
- RD1: rf_read_en=1, rf_read_addr=rs1; operand captured into rs1 register at end of cycle → RD2.
- RD2: rf_read_en=1, rf_read_addr=rs2; operand captured → HOLD.
- HOLD: out_valid=1; outputs stable until out_ready=1. On out_ready=1: in_ready=1; if in_valid=1, latch the new instruction → RD1; else → IDLE.
- Outside RD1/RD2: rf_read_en=0, rf_read_addr=0.
- Address 0 operand is always captured as 0, regardless of rf_read_data or snoop.
- Captured value (per operand) = rf_read_data, or wb_write_data when forwarding applies (see Configuration).
- Writes after an operand's capture cycle are ignored; hazard avoidance beyond the capture cycle is upstream's responsibility.
- in_valid is ignored in RD1/RD2 (in_ready=0). Upstream holds in_valid and addresses stable until in_ready=1.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, rf_read_en=0, rf_read_addr=0, out_rs1_data=0, out_rs2_data=0, out_rd_addr=0.
- rst=1 in any state (including mid-read or HOLD with out_ready=0) aborts the instruction; no output handshake occurs. All values return to reset values at the next edge.
- Latency: accept at edge E → RD1 during cycle E+1, RD2 during cycle E+2, out_valid=1 from cycle E+3.
- Throughput: one instruction per 3 cycles with out_ready held high (HOLD→RD1 back-to-back).
- in_ready is combinational from state and out_ready (HOLD only); out_valid is registered (state decode).
- rs1==rs2 is not special-cased: both reads still issued, fixed latency.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined: in RD1/RD2, if wb_write_en=1 and wb_write_addr==rf_read_addr!=0, capture wb_write_data instead of rf_read_data.
- Undefined: always capture rf_read_data (address-0 rule still applies); wb_* ports present but unused; upstream must stall around same-cycle writes.

## Test plan
- Reset: assert rst 2 cycles → in_ready=1, out_valid=0, rf_read_en=0, all data outputs 0.
- Basic read: RF x3=0x11, x5=0x22; accept rs1=3, rs2=5, rd=7 → cycle+1 rf_read_addr=3, cycle+2 rf_read_addr=5, cycle+3 out_valid=1, out_rs1_data=0x11, out_rs2_data=0x22, out_rd_addr=7.
- Zero register: rs1=0 with RF driving 0xDEADBEEF at address 0 → out_rs1_data=0.
- Bypass: during RD2 for rs2=5 (RF old 0x22), drive wb write x5=0x99 → with OPERAND_FETCH_BYPASS_EN out_rs2_data=0x99; without it, 0x22. Write of x5=0x77 in HOLD → output unchanged.
- Backpressure/back-to-back: hold out_ready=0 for 4 cycles in HOLD → outputs stable, in_ready=0; then out_ready=1 with in_valid=1 → next instruction enters RD1 next cycle, second out_valid exactly 3 cycles later.
- Mid-operation reset: assert rst during RD2 → next cycle IDLE, out_valid never asserts for that instruction.
